// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
package seg_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [13:0] BCD_MAX   = 14'd9999;
   localparam logic [6:0]  SEG_BLANK = 7'b1111111;

   // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
   localparam logic [6:0] SEG_TABLE [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      logic [6:0] pat;
      pat = SEG_BLANK;
      if (d <= 4'd9) pat = SEG_TABLE[d];
      return pat;
   endfunction

endpackage

// File: rtl/bcd_dd.sv
// Sequential double-dabble converter: 14-bit binary to 4-digit BCD, one bit per shift.
module bcd_dd (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        shift,
   input  logic [13:0] bin,
   output logic [15:0] bcd
);
   import seg_pkg::*;

   logic [13:0] src;
   logic [15:0] work;
   logic [15:0] adj;

   always_comb begin
      adj = work;
      for (int unsigned i = 0; i < 4; i++) begin
         if (work[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = work[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         src  <= '0;
         work <= '0;
      end else if (start) begin
         src  <= bin;
         work <= '0;
      end else if (shift) begin
         work <= {adj[14:0], src[13]};
         src  <= {src[12:0], 1'b0};
      end
   end

   assign bcd = work;

endmodule

// File: rtl/seg_scan_driver.sv
// Binary-to-BCD conversion and 4-digit multiplexed 7-segment scan.
// Optional leading-zero blanking via macro SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver #(
   parameter int unsigned SCAN_DIV = 2048
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] bin_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic        ovf_o,
   output logic [3:0]  an_o,
   output logic [6:0]  seg_o
);
   import seg_pkg::*;

   localparam int unsigned    PW       = $clog2(SCAN_DIV);
   localparam logic [PW-1:0]  PRE_LAST = PW'(SCAN_DIV - 1);

   state_t        state, state_nxt;
   logic [3:0]    cnt;
   logic          dd_start, dd_shift;
   logic [13:0]   bin_sat;
   logic [15:0]   bcd;
   logic [15:0]   disp;
   logic [PW-1:0] pre;
   logic [1:0]    idx;
   logic [3:0]    digit;

   assign bin_sat = (bin_i > BCD_MAX) ? BCD_MAX : bin_i;

   bcd_dd u_dd (
      .clk   (clk),
      .reset (reset),
      .start (dd_start),
      .shift (dd_shift),
      .bin   (bin_sat),
      .bcd   (bcd)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      dd_start  = 1'b0;
      dd_shift  = 1'b0;
      ready_o   = 1'b0;
      case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               dd_start  = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            dd_shift = 1'b1;
            if (cnt == 4'd13) state_nxt = COMMIT;
         end
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt   <= '0;
         ovf_o <= 1'b0;
         disp  <= '0;
      end else begin
         if (dd_start) begin
            cnt   <= '0;
            ovf_o <= (bin_i > BCD_MAX);
         end else if (dd_shift) begin
            cnt <= cnt + 4'd1;
         end
         if (state == COMMIT) disp <= bcd;
      end
   end

   // Scan runs independently of the converter so it never stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PRE_LAST) begin
         pre <= '0;
         idx <= idx + 2'd1;
      end else begin
         pre <= pre + 1'b1;
      end
   end

   assign an_o  = 4'b0001 << idx;
   assign digit = disp[{idx, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic lead_zero;

   always_comb begin
      lead_zero = 1'b0;
      case (idx)
         2'd3:    lead_zero = (disp[15:12] == 4'd0);
         2'd2:    lead_zero = (disp[15:8]  == 8'd0);
         2'd1:    lead_zero = (disp[15:4]  == 12'd0);
         default: lead_zero = 1'b0;
      endcase
   end

   assign seg_o = lead_zero ? SEG_BLANK : seg_decode(digit);
`else
   assign seg_o = seg_decode(digit);
`endif

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver against a cycle-level arithmetic reference model.
module tb_seg_scan_driver;

   localparam int unsigned DIV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [13:0] bin_i = '0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic        ovf_o;
   logic [3:0]  an_o;
   logic [6:0]  seg_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seg_scan_driver #(.SCAN_DIV(DIV)) dut (
      .clk     (clk),
      .reset   (reset),
      .bin_i   (bin_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .ovf_o   (ovf_o),
      .an_o    (an_o),
      .seg_o   (seg_o)
   );

   logic [6:0] seg_ref [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   // Reference: 1 accept cycle + 14 shift + 1 commit, so the display changes 15 edges after accept.
   int n_edges = 0;
   bit m_busy  = 1'b0;
   int m_left  = 0;
   int m_pend  = 0;
   int m_val   = 0;
   bit m_ovf   = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         n_edges = 0;
         m_busy  = 1'b0;
         m_left  = 0;
         m_val   = 0;
         m_ovf   = 1'b0;
      end else begin
         n_edges++;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_val  = m_pend;
               m_busy = 1'b0;
            end
         end else if (valid_i) begin
            m_busy = 1'b1;
            m_left = 15;
            m_pend = (int'(bin_i) > 9999) ? 9999 : int'(bin_i);
            m_ovf  = (int'(bin_i) > 9999);
         end
      end
   end

   function automatic logic [6:0] exp_seg(int v, int k);
      int p;
      p = 1;
      for (int i = 0; i < k; i++) p *= 10;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) return 7'b1111111;
`endif
      return seg_ref[(v / p) % 10];
   endfunction

   task automatic check(input string tag);
      int         k;
      logic       e_rdy;
      logic       e_ovf;
      logic [3:0] e_an;
      logic [6:0] e_seg;
      k     = (n_edges / DIV) % 4;
      e_rdy = ~m_busy;
      e_ovf = m_ovf;
      e_an  = 4'(1 << k);
      e_seg = exp_seg(m_val, k);
      tests++;
      assert (ready_o === e_rdy) else begin
         fails++; $error("FAIL %s ready_o got %b want %b", tag, ready_o, e_rdy);
      end
      tests++;
      assert (ovf_o === e_ovf) else begin
         fails++; $error("FAIL %s ovf_o got %b want %b", tag, ovf_o, e_ovf);
      end
      tests++;
      assert (an_o === e_an) else begin
         fails++; $error("FAIL %s an_o got %b want %b", tag, an_o, e_an);
      end
      tests++;
      assert (seg_o === e_seg) else begin
         fails++; $error("FAIL %s seg_o got %b want %b (disp %0d)", tag, seg_o, e_seg, m_val);
      end
   endtask

   task automatic cycles(input int n, input string tag);
      repeat (n) begin
         @(negedge clk);
         check(tag);
      end
   endtask

   task automatic seg_at(input logic [3:0] an_want, input logic [6:0] seg_want, input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < int'(4 * DIV + 2) && !found; i++) begin
         @(negedge clk);
         check(tag);
         if (an_o === an_want) found = 1'b1;
      end
      tests++;
      assert (found && seg_o === seg_want) else begin
         fails++; $error("FAIL %s an %b seg_o got %b want %b (found=%0d)", tag, an_want, seg_o, seg_want, found);
      end
   endtask

   task automatic send(input logic [13:0] v, input string tag);
      valid_i = 1'b1;
      bin_i   = v;
      cycles(1, tag);
      valid_i = 1'b0;
   endtask

   initial begin
      #12;
      check("reset");
      @(negedge clk);
      reset = 1'b1;
      cycles(4 * DIV + 3, "idle_scan");

      send(14'd1234, "acc1234");
      cycles(13, "conv1234");
      cycles(6, "commit1234");
      seg_at(4'b1000, 7'b1111001, "d3_1234");
      seg_at(4'b0001, 7'b0011001, "d0_1234");
      tests++;
      assert (ovf_o === 1'b0) else begin
         fails++; $error("FAIL ovf1234 got %b want 0", ovf_o);
      end

      send(14'd12000, "acc12000");
      cycles(20, "conv12000");
      tests++;
      assert (ovf_o === 1'b1) else begin
         fails++; $error("FAIL ovf12000 got %b want 1", ovf_o);
      end
      send(14'd5, "acc5");
      cycles(20, "conv5");

      send(14'd3000, "acc3000");
      cycles(4, "busy3000");
      valid_i = 1'b1;
      bin_i   = 14'd77;
      tests++;
      assert (ready_o === 1'b0) else begin
         fails++; $error("FAIL busy_ready got %b want 0", ready_o);
      end
      cycles(1, "ignored77");
      valid_i = 1'b0;
      cycles(20, "conv3000");

      send(14'd4321, "acc4321");
      cycles(7, "shift4321");
      #2 reset = 1'b0;
      #1 check("rst_mid");
      @(negedge clk);
      reset = 1'b1;
      cycles(30, "after_abort");

      repeat (400) begin
         valid_i = ($urandom_range(0, 3) == 0);
         bin_i   = 14'($urandom_range(0, 16383));
         cycles(1, "random");
      end
      valid_i = 1'b0;
      cycles(20, "drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter: SCAN_DIV, default 2048, clk cycles per digit slot (minimum 2).
REQ-002 SHALL have port: clk  input  1  system clock; all logic rises on posedge clk.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (reset==0 resets).
REQ-004 SHALL have port: bin_i  input  14  unsigned binary value to display.
REQ-005 SHALL have port: valid_i  input  1  bin_i valid; transfer occurs when valid_i && ready_o.
REQ-006 SHALL have port: ready_o  output  1  converter idle, able to accept bin_i.
REQ-007 SHALL have port: ovf_o  output  1  last accepted value exceeded 9999.
REQ-008 SHALL have port: an_o  output  4  digit enable, one-hot, active-high; bit0 is units.
REQ-009 SHALL have port: seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-010 SHALL provide FSM states IDLE, SHIFT, COMMIT; ready_o=1 only in IDLE.
REQ-011 IDLE: on valid_i=1, SHALL capture bin_i (saturated to 9999 if >9999), set ovf_o to (bin_i>9999), clear the BCD working register and shift count, and go to SHIFT.
REQ-012 SHIFT: SHALL perform one double-dabble step per cycle (add 3 to each BCD nibble >=5, then shift left 1 with the next MSB of the captured value), for exactly 14 cycles, then go to COMMIT.
REQ-013 COMMIT: SHALL load the 4 BCD digits into the display register in one cycle and return to IDLE.
REQ-014 Latency SHALL be 16 cycles from the accept edge to the display register update; ready_o SHALL be high again on the cycle after COMMIT.
REQ-015 valid_i while ready_o=0 SHALL be ignored (no queuing); the display register SHALL hold the previous value until COMMIT.
REQ-016 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->2->3->0.
REQ-017 an_o SHALL equal 1<<index; seg_o SHALL be the active-low decode of the display digit at index (0=7'b1000000, 1=7'b1111001, ..., 9=7'b0010000).
REQ-018 A COMMIT coinciding with a prescaler wrap SHALL show the new digit at the new index on the following cycle; the scan SHALL never stall.
REQ-019 Out-of-range nibbles (10-15) SHALL be unreachable; the decoder default SHALL be all segments off (7'b1111111).

Reset
REQ-020 reset=0 SHALL immediately force: FSM=IDLE, ready_o=1, ovf_o=0, display digits=0, prescaler=0, index=0, an_o=4'b0001, seg_o=7'b1000000.
REQ-021 Reset asserted mid-SHIFT SHALL abort the conversion with no COMMIT; the display SHALL show 0000.
REQ-022 Deassertion SHALL take effect on the first posedge clk with reset=1.

Configuration
REQ-023 Macro SEG_LEADING_ZERO_BLANK_EN defined: for thousands, hundreds, and tens, a zero digit with all more-significant digits zero SHALL drive seg_o=7'b1111111 while an_o still scans; units SHALL never be blanked.
REQ-024 Macro undefined: all four digits SHALL always be decoded, including leading zeros.

Structure
REQ-025 Package seg_pkg SHALL hold the FSM state enum, the 10-entry segment pattern constant table, SEG_BLANK, and BCD_MAX=9999.
REQ-026 The double-dabble datapath SHALL be a sub-module bcd_dd (start/shift control in, 16-bit BCD out); the scan and decode logic SHALL stay in seg_scan_driver.

Verification
REQ-027 Reset released, no input -> an_o cycles 0001,0010,0100,1000 every SCAN_DIV cycles; seg_o shows 7'b1000000 on every digit (macro off).
REQ-028 bin_i=1234 accepted -> after 16 cycles digits={1,2,3,4}; seg_o at index 3 = 7'b1111001, index 0 = 7'b0011001; ovf_o=0.
REQ-029 bin_i=12000 -> digits 9999, ovf_o=1; next bin_i=5 -> ovf_o=0, digits 0005.
REQ-030 Second valid_i asserted 5 cycles after an accept -> ignored (ready_o=0), display equals the first value only.
REQ-031 reset pulsed low at SHIFT cycle 7 of bin_i=4321 -> display 0000, ready_o=1, no later COMMIT.
REQ-032 SEG_LEADING_ZERO_BLANK_EN defined, bin_i=7 -> indices 3,2,1 give seg_o=7'b1111111, index 0 gives 7'b1111000; bin_i=0 -> units shows 7'b1000000.
